// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: 640x480@60 scan counters, sync decode and blanked, registered RGB output stage.
module vga_scan_ctrl #(
   parameter int DIV      = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] data_in,
   output logic [8:0]  row,
   output logic [9:0]  col,
   output logic        hs_n,
   output logic        vs_n,
   output logic [3:0]  r,
   output logic [3:0]  g,
   output logic [3:0]  b,
   output logic        vblank,
   output logic        frame_start
);
   localparam int DW = $clog2(DIV);
   localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
   localparam logic [9:0] H_A   = 10'(H_ACTIVE);
   localparam logic [9:0] H_SS  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_SE  = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] H_MAX = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_A   = 10'(V_ACTIVE);
   localparam logic [9:0] V_SS  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_SE  = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] V_MAX = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   logic [DW-1:0] div_cnt;
   logic [9:0]    h_cnt, v_cnt, h_nxt, v_nxt;
   logic          pix_en, h_end, v_end, active, hs_on, vs_on;

   always_comb begin
      pix_en = div_cnt == DIV_MAX;
      h_end  = h_cnt == H_MAX;
      v_end  = v_cnt == V_MAX;
      h_nxt  = h_end ? '0 : h_cnt + 10'd1;
      v_nxt  = h_end ? (v_end ? '0 : v_cnt + 10'd1) : v_cnt;
      active = (h_cnt < H_A) && (v_cnt < V_A);
      hs_on  = (h_cnt >= H_SS) && (h_cnt < H_SE);
      vs_on  = (v_cnt >= V_SS) && (v_cnt < V_SE);
      col    = h_cnt < H_A ? h_cnt : '0;
      row    = v_cnt < V_A ? v_cnt[8:0] : '0;
   end

   // Colour and sync come from the pre-increment counters, so they trail row/col by one pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt     <= '0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         hs_n        <= 1'b1;
         vs_n        <= 1'b1;
         {b, g, r}   <= '0;
         vblank      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         div_cnt     <= pix_en ? '0 : div_cnt + 1'b1;
         frame_start <= pix_en && h_end && v_end;
         if (pix_en) begin
            h_cnt     <= h_nxt;
            v_cnt     <= v_nxt;
            hs_n      <= !hs_on;
            vs_n      <= !vs_on;
            {b, g, r} <= active ? data_in : '0;
            vblank    <= v_nxt >= V_A;
         end
      end
   end
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: directed checks of scan timing, pixel pass-through and reset behaviour.
// Vertical geometry is shrunk to 10 lines so full frames fit a short run; horizontal is the real 800.
module tb_vga_scan_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] data_in;
   logic [8:0]  row;
   logic [9:0]  col;
   logic        hs_n, vs_n, vblank, frame_start;
   logic [3:0]  r, g, b;
   int          errors = 0, checks = 0, fs_cnt = 0;
   int unsigned cyc = 0, rel = 0, t0 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (frame_start === 1'b1) fs_cnt <= fs_cnt + 1;

   vga_scan_ctrl #(
      .DIV(4), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .row(row), .col(col),
      .hs_n(hs_n), .vs_n(vs_n), .r(r), .g(g), .b(b),
      .vblank(vblank), .frame_start(frame_start)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      data_in = 12'hfff;
      tick(3);
      chk("rst_hs_n", hs_n, 1);
      chk("rst_vs_n", vs_n, 1);
      chk("rst_rgb", {b, g, r}, 0);
      chk("rst_row", row, 0);
      chk("rst_col", col, 0);
      chk("rst_vblank", vblank, 0);
      chk("rst_frame_start", frame_start, 0);
      rst_n = 1'b1;
      rel   = cyc;
      tick(3);
      chk("col_before_first_pix", col, 0);
      tick(1);
      chk("col_first_pix", col, 1);
      for (int i = 0; i < 4000 && hs_n !== 1'b0; i++) tick(1);
      chk("hs_first_fall", cyc - rel, 2628);
      t0 = cyc;
      for (int i = 0; i < 1000 && hs_n !== 1'b1; i++) tick(1);
      chk("hs_low_width", cyc - t0, 384);
      for (int i = 0; i < 4000 && hs_n !== 1'b0; i++) tick(1);
      chk("hs_period", cyc - t0, 3200);
      for (int i = 0; i < 20000 && !(row == 9'd5 && col == 10'd10); i++) tick(1);
      data_in = 12'h00f;
      tick(4);
      chk("pass_rgb", {b, g, r}, 12'h00f);
      data_in = 12'h0f0;
      tick(1);
      data_in = 12'hf00;
      tick(1);
      data_in = 12'h0f0;
      tick(1);
      data_in = 12'hf00;
      tick(1);
      chk("window_rgb", {b, g, r}, 12'hf00);
      data_in = 12'h0f0;
      tick(3);
      chk("window_hold", {b, g, r}, 12'hf00);
      data_in = 12'hfff;
      for (int i = 0; i < 4000 && col !== 10'd639; i++) tick(1);
      tick(4);
      chk("active_rgb_col639", {b, g, r}, 12'hfff);
      tick(244);
      chk("blank_rgb_h700", {b, g, r}, 0);
      chk("blank_hs_h700", hs_n, 0);
      chk("blank_col_h701", col, 0);
      for (int i = 0; i < 4000 && vblank !== 1'b1; i++) tick(1);
      chk("vblank_rise", cyc - rel, 19200);
      chk("vblank_row", row, 0);
      for (int i = 0; i < 8000 && vs_n !== 1'b0; i++) tick(1);
      chk("vs_fall", cyc - rel, 22404);
      t0 = cyc;
      for (int i = 0; i < 8000 && vs_n !== 1'b1; i++) tick(1);
      chk("vs_low_width", cyc - t0, 6400);
      for (int i = 0; i < 8000 && frame_start !== 1'b1; i++) tick(1);
      chk("frame_period", cyc - rel, 32000);
      chk("frame_vblank_clear", vblank, 0);
      chk("frame_col", col, 0);
      tick(1);
      chk("frame_start_width", frame_start, 0);
      chk("frame_start_count", fs_cnt, 1);
      for (int i = 0; i < 12000 && !(row == 9'd3 && col == 10'd400); i++) tick(1);
      chk("mid_rgb_before", {b, g, r}, 12'hfff);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_col", col, 0);
      chk("mid_rst_row", row, 0);
      chk("mid_rst_rgb", {b, g, r}, 0);
      tick(3);
      rst_n = 1'b1;
      rel   = cyc;
      for (int i = 0; i < 4000 && hs_n !== 1'b0; i++) tick(1);
      chk("mid_hs_first_fall", cyc - rel, 2628);
      chk("mid_frame_start_count", fs_cnt, 1);
      chk("mid_vblank", vblank, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
